// File: rtl/sevseg_pkg.sv
// Shared definitions for the 7-segment display path.
// Holds the active-high (segment lit) code table used by both the display
// driver and the readback monitor, plus the reader FSM state type.
// Segment bit order: bit6=g ... bit0=a.
package sevseg_pkg;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_F     = 7'b1110001;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_REPORT = 2'd2
    } reader_state_t;

endpackage

// File: rtl/sevseg_pattern_decode.sv
// Combinational decode of an active-high 7-segment pattern.
// Ports:
//   seg   in  7  pattern, 1 = segment lit
//   bin   out 4  decoded value (0 for blank or unknown patterns)
//   blank out 1  all segments off
//   error out 1  pattern not in the code table
// blank and error are mutually exclusive.
module sevseg_pattern_decode
    import sevseg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] bin,
    output logic       blank,
    output logic       error
);

    always_comb begin
        bin   = 4'd0;
        blank = 1'b0;
        error = 1'b0;
        case (seg)
            SEG_0:     bin = 4'd0;
            SEG_1:     bin = 4'd1;
            SEG_2:     bin = 4'd2;
            SEG_3:     bin = 4'd3;
            SEG_4:     bin = 4'd4;
            SEG_5:     bin = 4'd5;
            SEG_6:     bin = 4'd6;
            SEG_7:     bin = 4'd7;
            SEG_8:     bin = 4'd8;
            SEG_9:     bin = 4'd9;
            SEG_A:     bin = 4'd10;
            SEG_F:     bin = 4'd15;
            SEG_BLANK: blank = 1'b1;
            default:   error = 1'b1;
        endcase
    end

endmodule

// File: rtl/sevseg_reader.sv
// Readback monitor for an active-low 7-segment display.
// Samples the pattern, waits for it to be stable for STABLE_CYCLES samples,
// then reports the decoded value with a one-cycle o_valid pulse. Patterns
// outside the code table are flagged and counted (saturating).
// Ports:
//   i_clk        in  1          clock
//   i_rst_n      in  1          async reset, active-low
//   i_sevseg     in  7          segment pattern, active-low, bit6=g..bit0=a
//   o_valid      out 1          one-cycle report pulse
//   o_bin_num    out 4          decoded value, held between reports
//   o_blank      out 1          reported pattern was blank
//   o_error      out 1          reported pattern was undecodable
//   o_err_count  out ERR_CNT_W  saturating count of error reports
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | pattern equals last report; wait for a change
// ST_SETTLE | new candidate seen; counting consecutive identical samples
// ST_REPORT | single cycle after a report; input ignored this cycle
module sevseg_reader
    import sevseg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [6:0]           i_sevseg,
    output logic                 o_valid,
    output logic [3:0]           o_bin_num,
    output logic                 o_blank,
    output logic                 o_error,
    output logic [ERR_CNT_W-1:0] o_err_count
);

    localparam int               CNT_W    = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [6:0]       RAW_BLANK = 7'h7F;

    reader_state_t    state;
    reader_state_t    state_nxt;
    logic [6:0]       s_reg;
    logic [6:0]       cand;
    logic [6:0]       last_rep;
    logic [CNT_W-1:0] cnt;

    logic             load_cand;
    logic             cnt_inc;
    logic             report_go;

    logic [6:0]       cand_lit;
    logic [3:0]       dec_bin;
    logic             dec_blank;
    logic             dec_error;

    // The code table is active-high; the display bus is active-low.
    assign cand_lit = ~cand;

    sevseg_pattern_decode u_decode (
        .seg   (cand_lit),
        .bin   (dec_bin),
        .blank (dec_blank),
        .error (dec_error)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load_cand = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (s_reg != last_rep) begin
                    load_cand = 1'b1;
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                // A glitch that falls back to the shown value is dropped.
                if (s_reg == last_rep) begin
                    state_nxt = ST_IDLE;
                end else if (s_reg != cand) begin
                    load_cand = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_REPORT;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_REPORT: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        report_go = (state == ST_SETTLE) && (state_nxt == ST_REPORT);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s_reg <= RAW_BLANK;
            cand  <= RAW_BLANK;
            cnt   <= '0;
        end else begin
            s_reg <= i_sevseg;
            if (load_cand) begin
                cand <= s_reg;
                cnt  <= CNT_ONE;
            end else if (cnt_inc) begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid     <= 1'b0;
            o_bin_num   <= 4'd0;
            o_blank     <= 1'b0;
            o_error     <= 1'b0;
            o_err_count <= '0;
            last_rep    <= RAW_BLANK;
        end else begin
            o_valid <= report_go;
            if (report_go) begin
                o_bin_num <= dec_bin;
                o_blank   <= dec_blank;
                o_error   <= dec_error;
                last_rep  <= cand;
                if (dec_error && (o_err_count != {ERR_CNT_W{1'b1}})) begin
                    o_err_count <= o_err_count + 1'b1;
                end
            end
        end
    end

endmodule
